// File: rtl/infernet_net_pkg.sv
// infernet_net_pkg: shared types and Ethernet/IPv4/UDP byte offsets for the
// network ingress path.
package infernet_net_pkg;

    typedef enum logic [1:0] {HDR, PAY, DROP, DONE} state_e;

    // Byte position within a frame, counted from the first destination-MAC byte.
    typedef logic [10:0] bcnt_t;

    localparam bcnt_t ETH_SRC  = 11'd6;
    localparam bcnt_t ETH_TYPE = 11'd12;
    localparam bcnt_t IP_VIHL  = 11'd14;
    localparam bcnt_t IP_PROTO = 11'd23;
    localparam bcnt_t IP_SRC   = 11'd26;
    localparam bcnt_t IP_DST   = 11'd30;
    localparam bcnt_t UDP_SRC  = 11'd34;
    localparam bcnt_t UDP_DST  = 11'd36;
    localparam bcnt_t PAYLOAD  = 11'd42;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_UDP      = 8'h11;
    // Version 4 with a 5-word header: options are not supported.
    localparam logic [7:0]  IP_VIHL_V4     = 8'h45;

endpackage

// File: rtl/udp_frame_rx.sv
// udp_frame_rx: parses Ethernet/IPv4/UDP frames from the MAC stream, keeps only
// those addressed to LOCAL_IP:LOCAL_PORT, writes the first USER_DATA_BYTES
// payload bytes into the image buffer and pulses FRAME_READY per good frame.
module udp_frame_rx
    import infernet_net_pkg::*;
#(
    parameter int          USER_DATA_BYTES = 784,
    parameter logic [31:0] LOCAL_IP        = 32'hC0A8_0164,
    parameter logic [15:0] LOCAL_PORT      = 16'd5000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [7:0]  S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    input  logic        NN_BUSY,
    output logic [7:0]  RX_DATA,
    output logic [9:0]  RX_ADDR,
    output logic        RX_EN,
    output logic [0:47] SRC_MAC_ADDRESS_IP,
    output logic [0:31] SRC_IP_ADDRESS_IP,
    output logic [0:15] SRC_UDP_PORT_IP,
    output logic        FRAME_READY,
    output logic [15:0] FRAMES_OK,
    output logic [15:0] FRAMES_DROPPED
);

    localparam bcnt_t PAY_LIMIT = bcnt_t'(USER_DATA_BYTES);

    state_e      state_q, state_d;
    bcnt_t       bcnt_q, bcnt_d;
    bcnt_t       pay_idx;
    logic        beat;
    logic        wr_req;
    logic        drop_inc;

    logic        rx_en_q;
    logic [9:0]  rx_addr_q;
    logic [7:0]  rx_data_q;
    logic [0:47] mac_sh_q;
    logic [0:31] ip_sh_q;
    logic [0:15] port_sh_q;
    logic [0:47] src_mac_q;
    logic [0:31] src_ip_q;
    logic [0:15] src_port_q;
    logic [15:0] frames_ok_q;
    logic [15:0] frames_drop_q;

    // True when this byte position carries no check, or carries one and matches.
    function automatic logic hdr_byte_ok(input bcnt_t idx, input logic [7:0] b);
        logic ok;
        ok = 1'b1;
        case (idx)
            ETH_TYPE:          ok = (b == ETHERTYPE_IPV4[15:8]);
            ETH_TYPE + 11'd1:  ok = (b == ETHERTYPE_IPV4[7:0]);
            IP_VIHL:           ok = (b == IP_VIHL_V4);
            IP_PROTO:          ok = (b == PROTO_UDP);
            IP_DST:            ok = (b == LOCAL_IP[31:24]);
            IP_DST + 11'd1:    ok = (b == LOCAL_IP[23:16]);
            IP_DST + 11'd2:    ok = (b == LOCAL_IP[15:8]);
            IP_DST + 11'd3:    ok = (b == LOCAL_IP[7:0]);
            UDP_DST:           ok = (b == LOCAL_PORT[15:8]);
            UDP_DST + 11'd1:   ok = (b == LOCAL_PORT[7:0]);
            default:           ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Hold off only the first byte of a frame while the buffer is being read;
    // DONE is the idle slot of a back-to-back frame, so it is gated like HDR.
    assign S_AXIS_TREADY = !((state_q == HDR || state_q == DONE) && bcnt_q == '0 && NN_BUSY)
                           || state_q == DROP;
    assign beat    = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pay_idx = bcnt_q - PAYLOAD;

    // Next state, beat counter and per-beat write/drop strobes.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        wr_req   = 1'b0;
        drop_inc = 1'b0;
        if (state_q == DONE) state_d = HDR;
        if (beat) begin
            // Saturate rather than wrap so an oversize frame never re-enters the header window.
            if (S_AXIS_TLAST)        bcnt_d = '0;
            else if (bcnt_q != '1)   bcnt_d = bcnt_q + 11'd1;
            case (state_q)
                HDR, DONE: begin
                    if (S_AXIS_TLAST)                              drop_inc = 1'b1;
                    else if (!hdr_byte_ok(bcnt_q, S_AXIS_TDATA))   state_d  = DROP;
                    else if (bcnt_q == PAYLOAD - 11'd1)            state_d  = PAY;
                end
                PAY: begin
                    wr_req = (pay_idx < PAY_LIMIT);
                    if (S_AXIS_TLAST) begin
                        if (pay_idx >= PAY_LIMIT - 11'd1) begin
                            state_d = DONE;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = HDR;
                        end
                    end
                end
                DROP: begin
                    if (S_AXIS_TLAST) begin
                        drop_inc = 1'b1;
                        state_d  = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Parser state and byte counter.
    always_ff @(posedge ACLK) begin
        // NOTE: ARESET is synchronous and active-high; sequential state takes non-blocking assignments only.
        if (ARESET) begin
            state_q <= HDR;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Registered buffer write port: a payload beat accepted in cycle t writes in t+1.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rx_en_q   <= 1'b0;
            rx_addr_q <= '0;
            rx_data_q <= '0;
        end else begin
            rx_en_q <= wr_req;
            if (wr_req) begin
                rx_addr_q <= pay_idx[9:0];
                rx_data_q <= S_AXIS_TDATA;
            end
        end
    end

    // Capture sender fields while the header streams past.
    // NOTE: shadows are pure data, always rewritten by a frame before DONE can copy them, so they have no reset.
    always_ff @(posedge ACLK) begin
        if (beat && (state_q == HDR || state_q == DONE)) begin
            if (bcnt_q >= ETH_SRC && bcnt_q < ETH_TYPE) mac_sh_q  <= {mac_sh_q[8:47], S_AXIS_TDATA};
            if (bcnt_q >= IP_SRC  && bcnt_q < IP_DST)   ip_sh_q   <= {ip_sh_q[8:31], S_AXIS_TDATA};
            if (bcnt_q >= UDP_SRC && bcnt_q < UDP_DST)  port_sh_q <= {port_sh_q[8:15], S_AXIS_TDATA};
        end
    end

    // Publish sender fields and count outcomes; loading on entry to DONE makes them valid with FRAME_READY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            src_mac_q     <= '0;
            src_ip_q      <= '0;
            src_port_q    <= '0;
            frames_ok_q   <= '0;
            frames_drop_q <= '0;
        end else begin
            if (state_d == DONE) begin
                src_mac_q   <= mac_sh_q;
                src_ip_q    <= ip_sh_q;
                src_port_q  <= port_sh_q;
                frames_ok_q <= frames_ok_q + 16'd1;
            end
            if (drop_inc) frames_drop_q <= frames_drop_q + 16'd1;
        end
    end

    assign RX_EN              = rx_en_q;
    assign RX_ADDR            = rx_addr_q;
    assign RX_DATA            = rx_data_q;
    assign FRAME_READY        = (state_q == DONE);
    assign SRC_MAC_ADDRESS_IP = src_mac_q;
    assign SRC_IP_ADDRESS_IP  = src_ip_q;
    assign SRC_UDP_PORT_IP    = src_port_q;
    assign FRAMES_OK          = frames_ok_q;
    assign FRAMES_DROPPED     = frames_drop_q;

endmodule

// File: tb/tb_udp_frame_rx.sv
// tb_udp_frame_rx: directed and randomized frames for udp_frame_rx, checked
// against a frame-level reference model of the filter and payload rules.
module tb_udp_frame_rx;

    localparam int          UDB   = 784;
    localparam logic [31:0] LIP   = 32'hC0A8_0164;
    localparam logic [15:0] LPORT = 16'd5000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        nn_busy = 1'b0;
    logic [7:0]  rx_data;
    logic [9:0]  rx_addr;
    logic        rx_en;
    logic [0:47] src_mac;
    logic [0:31] src_ip;
    logic [0:15] src_port;
    logic        frame_ready;
    logic [15:0] fok;
    logic [15:0] fdrop;

    udp_frame_rx #(.USER_DATA_BYTES(UDB), .LOCAL_IP(LIP), .LOCAL_PORT(LPORT)) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .S_AXIS_TDATA       (tdata),
        .S_AXIS_TVALID      (tvalid),
        .S_AXIS_TLAST       (tlast),
        .S_AXIS_TREADY      (tready),
        .NN_BUSY            (nn_busy),
        .RX_DATA            (rx_data),
        .RX_ADDR            (rx_addr),
        .RX_EN              (rx_en),
        .SRC_MAC_ADDRESS_IP (src_mac),
        .SRC_IP_ADDRESS_IP  (src_ip),
        .SRC_UDP_PORT_IP    (src_port),
        .FRAME_READY        (frame_ready),
        .FRAMES_OK          (fok),
        .FRAMES_DROPPED     (fdrop)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor-owned records of buffer writes and FRAME_READY pulses.
    logic [9:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         fr_total = 0;
    int         fr_cyc = -1;

    // Stimulus-owned state.
    logic [7:0]  frm[$];
    int          tlast_cyc;
    int          stall_mid;
    logic [15:0] exp_ok_cnt = '0;
    logic [15:0] exp_drop_cnt = '0;
    logic [47:0] exp_mac = '0;
    logic [31:0] exp_ip = '0;
    logic [15:0] exp_port = '0;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (rx_en) begin
                wr_addr_q.push_back(rx_addr);
                wr_data_q.push_back(rx_data);
            end
            if (frame_ready) begin
                fr_total = fr_total + 1;
                fr_cyc   = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: a frame is forwarded only if it is long enough to
    // reach the payload and every filtered header field matches.
    function automatic void model(output int nwr, output bit ok);
        int len;
        bit hdr;
        len = frm.size();
        hdr = 1'b0;
        nwr = 0;
        ok  = 1'b0;
        if (len > 42)
            hdr = ({frm[12], frm[13]} == 16'h0800) && (frm[14] == 8'h45) && (frm[23] == 8'h11)
                  && ({frm[30], frm[31], frm[32], frm[33]} == LIP) && ({frm[36], frm[37]} == LPORT);
        if (hdr) begin
            nwr = (len - 42 < UDB) ? len - 42 : UDB;
            ok  = (len - 42 >= UDB);
        end
    endfunction

    // fault: 1 bad ethertype, 2 bad version/IHL, 3 bad protocol; trunc > 0 cuts the frame.
    task automatic build_frame(input logic [47:0] smac, input logic [31:0] sip, input logic [15:0] sport,
                               input logic [31:0] dip, input logic [15:0] dport, input int plen,
                               input bit ramp, input int fault, input int trunc);
        logic [47:0] dmac;
        logic [15:0] len16;
        dmac = 48'h02_00_5E_00_01_64;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'(dmac >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) frm.push_back(8'(smac >> (40 - 8 * i)));
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h45); frm.push_back(8'h00);
        len16 = 16'(28 + plen);
        frm.push_back(len16[15:8]); frm.push_back(len16[7:0]);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'd64); frm.push_back(8'h11);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) frm.push_back(8'(sip >> (24 - 8 * i)));
        for (int i = 0; i < 4; i++) frm.push_back(8'(dip >> (24 - 8 * i)));
        frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        len16 = 16'(8 + plen);
        frm.push_back(len16[15:8]); frm.push_back(len16[7:0]);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        for (int k = 0; k < plen; k++) frm.push_back(ramp ? 8'(k) : 8'($urandom));
        case (fault)
            1:       frm[12] = 8'h86;
            2:       frm[14] = 8'h46;
            3:       frm[23] = 8'h06;
            default: ;
        endcase
        while (trunc > 0 && frm.size() > trunc) void'(frm.pop_back());
    endtask

    // Drive frm from a negedge; returns at the negedge after the last handshake.
    task automatic send_frame(input bit with_last, input bit gaps, input bit busy_noise);
        int  n;
        int  waited;
        bit  done;
        n = frm.size();
        stall_mid = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    tvalid = 1'b0;
                    @(negedge ACLK);
                end
            end
            tdata  = frm[i];
            tvalid = 1'b1;
            tlast  = with_last && (i == n - 1);
            if (busy_noise && i > 0) nn_busy = 1'($urandom_range(0, 1));
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                #1;
                if (tready) begin
                    done = 1'b1;
                    if (tlast) tlast_cyc = cyc;
                end else begin
                    if (i > 0) stall_mid++;
                    waited++;
                    if (waited > 300) begin
                        check("tready_timeout", 64'd0, 64'd1);
                        tvalid  = 1'b0;
                        tlast   = 1'b0;
                        nn_busy = 1'b0;
                        return;
                    end
                end
                @(negedge ACLK);
            end
        end
        tvalid  = 1'b0;
        tlast   = 1'b0;
        nn_busy = 1'b0;
    endtask

    task automatic compare_writes(input string tag, input int base, input int exp_nwr);
        int got;
        int bad;
        got = wr_addr_q.size() - base;
        bad = 0;
        check({tag, "_nwr"}, 64'(got), 64'(exp_nwr));
        for (int k = 0; k < got && k < exp_nwr; k++)
            if (wr_addr_q[base + k] !== 10'(k) || wr_data_q[base + k] !== frm[42 + k]) bad++;
        check({tag, "_wr_bad"}, 64'(bad), 64'd0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ok_cnt"}, 64'(fok), 64'(exp_ok_cnt));
        check({tag, "_drop_cnt"}, 64'(fdrop), 64'(exp_drop_cnt));
        check({tag, "_src_mac"}, 64'(src_mac), 64'(exp_mac));
        check({tag, "_src_ip"}, 64'(src_ip), 64'(exp_ip));
        check({tag, "_src_port"}, 64'(src_port), 64'(exp_port));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_en"}, 64'(rx_en), 64'd0);
        check({tag, "_rx_addr"}, 64'(rx_addr), 64'd0);
        check({tag, "_rx_data"}, 64'(rx_data), 64'd0);
        check({tag, "_frame_ready"}, 64'(frame_ready), 64'd0);
        check_outputs(tag);
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit busy_noise);
        int exp_nwr;
        bit exp_ok;
        int base;
        int fr_base;
        model(exp_nwr, exp_ok);
        base    = wr_addr_q.size();
        fr_base = fr_total;
        send_frame(1'b1, gaps, busy_noise);
        repeat (4) @(negedge ACLK);
        if (exp_ok) begin
            exp_ok_cnt++;
            exp_mac  = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
            exp_ip   = {frm[26], frm[27], frm[28], frm[29]};
            exp_port = {frm[34], frm[35]};
        end else begin
            exp_drop_cnt++;
        end
        compare_writes(tag, base, exp_nwr);
        check({tag, "_ready_cnt"}, 64'(fr_total - fr_base), 64'(exp_ok));
        if (exp_ok) check({tag, "_ready_cycle"}, 64'(fr_cyc), 64'(tlast_cyc + 1));
        check({tag, "_mid_stall"}, 64'(stall_mid), 64'd0);
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] full[$];
        int         held;
        int         fault;
        int         plen;
        logic [31:0] dip;
        logic [15:0] dport;
        int         base;
        int         exp_nwr;
        bit         exp_ok;

        repeat (3) @(negedge ACLK);
        check_reset_values("reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        check_reset_values("post_reset");

        // Good frame: ramp payload from 10.0.0.7:1234.
        build_frame(48'h02_11_22_33_44_55, 32'h0A00_0007, 16'd1234, LIP, LPORT, UDB, 1'b1, 0, 0);
        run_frame("good", 1'b1, 1'b0);
        check("good_ip_const", 64'(src_ip), 64'h0A00_0007);
        check("good_port_const", 64'(src_port), 64'd1234);

        // Wrong destination port.
        build_frame(48'h02_AA_BB_CC_DD_EE, 32'h0A00_0009, 16'd777, LIP, 16'd5001, UDB, 1'b1, 0, 0);
        run_frame("bad_port", 1'b0, 1'b0);

        // Short payload.
        build_frame(48'h02_01_02_03_04_05, 32'h0A00_0010, 16'd4321, LIP, LPORT, 500, 1'b1, 0, 0);
        run_frame("short", 1'b1, 1'b0);

        // Oversize payload: only the first UDB bytes are written.
        build_frame({16'h0200, $urandom}, $urandom, 16'($urandom), LIP, LPORT, 800, 1'b0, 0, 0);
        run_frame("long", 1'b1, 1'b1);

        // NN_BUSY holds off the first byte of the next frame.
        build_frame({16'h0200, $urandom}, $urandom, 16'($urandom), LIP, LPORT, UDB, 1'b0, 0, 0);
        nn_busy = 1'b1;
        tdata   = frm[0];
        tvalid  = 1'b1;
        held    = 0;
        repeat (8) begin
            #1;
            if (!tready) held++;
            @(negedge ACLK);
        end
        check("busy_hold", 64'(held), 64'd8);
        nn_busy = 1'b0;
        #1;
        check("busy_release_tready", 64'(tready), 64'd1);
        tvalid = 1'b0;
        @(negedge ACLK);
        run_frame("after_busy", 1'b0, 1'b0);

        // Randomized frames with header faults, truncation and varied lengths.
        for (int i = 0; i < 8; i++) begin
            fault = $urandom_range(0, 6);
            case ($urandom_range(0, 2))
                0:       plen = $urandom_range(0, 100);
                1:       plen = UDB + $urandom_range(0, 40);
                default: plen = $urandom_range(700, UDB);
            endcase
            dip   = (fault == 4) ? (LIP ^ (32'd1 << $urandom_range(0, 31))) : LIP;
            dport = (fault == 5) ? (LPORT ^ (16'd1 << $urandom_range(0, 15))) : LPORT;
            build_frame({16'h0200, $urandom}, $urandom, 16'($urandom), dip, dport, plen, 1'b0,
                        (fault <= 3) ? fault : 0, (fault == 6) ? $urandom_range(1, 42) : 0);
            run_frame($sformatf("rnd%0d", i), 1'b1, 1'b1);
        end

        // Reset at payload byte 300, then feed the rest of that frame and a good frame.
        build_frame(48'h02_DE_AD_BE_EF_01, 32'h0A00_0042, 16'd999, LIP, LPORT, UDB, 1'b1, 0, 0);
        full = frm;
        frm  = full[0:341];
        model(exp_nwr, exp_ok);
        base = wr_addr_q.size();
        send_frame(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge ACLK);
        compare_writes("abort_part", base, exp_nwr);
        check("abort_part_no_ready", 64'(frame_ready), 64'd0);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        exp_ok_cnt   = '0;
        exp_drop_cnt = '0;
        exp_mac      = '0;
        exp_ip       = '0;
        exp_port     = '0;
        check_reset_values("mid_reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        frm = full[342:$];
        run_frame("abort_tail", 1'b0, 1'b0);
        build_frame(48'h02_12_34_56_78_9A, 32'h0A00_0077, 16'd2024, LIP, LPORT, UDB, 1'b1, 0, 0);
        run_frame("post_abort_good", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
